// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
// Widths are functions of N so the top can be re-parameterized without touching this file.
package div_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int dvd_w(input int n);
        return 2 * n;
    endfunction

    function automatic int rem_w(input int n);
        return n + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_rem,
    output logic         o_qbit
);

    logic [N+1:0] w_shift;
    logic [N:0]   w_diff;

    // i_rem < divisor on entry, so the N+1-bit difference is exact whenever o_qbit is set
    assign w_shift = {i_rem, i_bit};
    assign o_qbit  = (w_shift >= {2'b00, i_divisor});
    assign w_diff  = w_shift[N:0] - {1'b0, i_divisor};
    assign o_rem   = o_qbit ? w_diff : w_shift[N:0];

endmodule

// File: rtl/divider_8b.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock,
// valid/ready on both sides. All outputs are registers or a decode of the state register.
module divider_8b
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [dvd_w(N)-1:0]   dividend,
    input  logic [N-1:0]          divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dvd_w(N)-1:0]   quotient,
    output logic [N-1:0]          remainder,
    output logic                  div_zero
);

    localparam int W2 = dvd_w(N);
    localparam int WR = rem_w(N);
    localparam int CW = cnt_w(N);

    div_state_e    r_state;
    div_state_e    w_state_nxt;
    logic [W2-1:0] r_q;
    logic [WR-1:0] r_rem;
    logic [N-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_dz;

    logic [WR-1:0] w_rem_nxt;
    logic          w_qbit;
    logic          w_accept;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;

    assign quotient  = r_q;
    assign remainder = r_rem[N-1:0];
    assign div_zero  = r_dz;

    div_step #(.N(N)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_q[W2-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The quotient register doubles as the dividend shift register: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dvs <= divisor;
                        r_rem <= '0;
                        r_cnt <= CW'(W2 - 1);
                        if (divisor == '0) begin
                            r_q  <= '1;
                            r_dz <= 1'b1;
                        end else begin
                            r_q  <= dividend;
                            r_dz <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_q   <= {r_q[W2-2:0], w_qbit};
                    r_rem <= w_rem_nxt;
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_8b.sv
// Self-checking bench for divider_8b (N=4): directed vector table, backpressure and
// async-reset sequences, randomized ops against a plain-arithmetic model, round-trip sweep.
module tb_divider_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t tv[8];

    divider_8b #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all-ones quotient.
    task automatic model(input int a, input int b, output int q, output int r, output int dz);
        if (b == 0) begin q = 255; r = 0; dz = 1; end
        else        begin q = a / b; r = a % b; dz = 0; end
    endtask

    // Present an operand pair, wait for acceptance, then count edges until out_valid.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          output int q, output int r, output int dz, output int lat);
        int w;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("accept_timeout", int'(w >= 30), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_zero;
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("ack_in_ready", in_ready, 1);
        chk("ack_out_valid", out_valid, 0);
    endtask

    initial begin
        int q, r, dz, lat;
        int eq, er, edz;
        int seen;
        logic [7:0] a;
        logic [3:0] b;

        tv[0] = '{a: 8'd143, b: 4'd11, q: 8'd13,  r: 4'd0,  dz: 1'b0, lat: 8};
        tv[1] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4,  dz: 1'b0, lat: 8};
        tv[2] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0,  dz: 1'b0, lat: 8};
        tv[3] = '{a: 8'd0,   b: 4'd15, q: 8'd0,   r: 4'd0,  dz: 1'b0, lat: 8};
        tv[4] = '{a: 8'd77,  b: 4'd0,  q: 8'd255, r: 4'd0,  dz: 1'b1, lat: 0};
        tv[5] = '{a: 8'd254, b: 4'd15, q: 8'd16,  r: 4'd14, dz: 1'b0, lat: 8};
        tv[6] = '{a: 8'd14,  b: 4'd15, q: 8'd0,   r: 4'd14, dz: 1'b0, lat: 8};
        tv[7] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0,  dz: 1'b0, lat: 8};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].a, tv[i].b, q, r, dz, lat);
            chk($sformatf("vec%0d_quotient", i), q, tv[i].q);
            chk($sformatf("vec%0d_remainder", i), r, tv[i].r);
            chk($sformatf("vec%0d_div_zero", i), dz, tv[i].dz);
            chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
            ack();
        end

        // Backpressure: hold the result while the inputs churn and in_valid is asserted.
        run_op(8'd200, 4'd7, q, r, dz, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(posedge clk);
            #1;
            chk("bp_quotient", quotient, 28);
            chk("bp_remainder", remainder, 4);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ack();

        // Asynchronous reset in the middle of RUN, between clock edges.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("arst_no_stale_valid", seen, 0);
        run_op(8'd143, 4'd11, q, r, dz, lat);
        chk("arst_next_quotient", q, 13);
        chk("arst_next_remainder", r, 0);
        chk("arst_next_latency", lat, 8);
        ack();

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            b = (i % 10 == 0) ? 4'd0 : 4'($urandom);
            model(int'(a), int'(b), eq, er, edz);
            run_op(a, b, q, r, dz, lat);
            chk($sformatf("rnd_%0d/%0d_quotient", a, b), q, eq);
            chk($sformatf("rnd_%0d/%0d_remainder", a, b), r, er);
            chk($sformatf("rnd_%0d/%0d_div_zero", a, b), dz, edz);
            chk($sformatf("rnd_%0d/%0d_latency", a, b), lat, (b == 0) ? 0 : 8);
            ack();
        end

        // Round-trip against the multiplier: (x*y)/y back-to-back with out_ready held high.
        out_ready = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                run_op(8'(x * y), 4'(y), q, r, dz, lat);
                chk($sformatf("rt_%0dx%0d_quotient", x, y), q, x);
                chk($sformatf("rt_%0dx%0d_remainder", x, y), r, 0);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
